game_link_tx: RTL and testbench

Transmit half of the inter-board game link. Turns local game events into fixed 5-byte frames and feeds them, one byte at a time, to the UART transmitter over a valid/ready byte handshake. Events are local enter press, local turn completion, local HP change, plus a periodic heartbeat. Sits between game_fsm (local side) and the UART TX core; the peer board decodes these frames into its enter_pressed_remote, turn_done and hp_remote inputs.

---
 rtl/game_link_pkg.sv | 34 +++
 rtl/game_link_hb_timer.sv | 34 +++
 rtl/game_link_tx.sv | 161 ++++++++++++++++
 tb/tb_game_link_tx.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_link_pkg.sv
`default_nettype none
// ============================================================================
// game_link_pkg : frame types, constants and tx FSM states for the game link
// Revision      : 1.0
// ============================================================================
package game_link_pkg;

  typedef enum logic [7:0] {
    FT_ENTER = 8'h01,
    FT_TURN  = 8'h02,
    FT_HP    = 8'h03,
    FT_HB    = 8'h04
  } frame_type_e;

  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
  localparam int         FRAME_LEN    = 5;

  typedef logic [2:0] tx_state_t;

  // Non-idle states double as the 1-based byte index within the frame
  localparam tx_state_t ST_IDLE = 3'd0;
  localparam tx_state_t ST_SYNC = 3'd1;
  localparam tx_state_t ST_TYPE = 3'd2;
  localparam tx_state_t ST_PHI  = 3'd3;
  localparam tx_state_t ST_PLO  = 3'd4;
  localparam tx_state_t ST_CHK  = tx_state_t'(FRAME_LEN);

  function automatic logic [7:0] frame_chk(input logic [7:0] type_byte,
                                           input logic [15:0] payload);
    return type_byte ^ payload[15:8] ^ payload[7:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/game_link_hb_timer.sv
`default_nettype none
// ============================================================================
// game_link_hb_timer : free-running 0..HB_PERIOD-1 counter, tick at terminal
// Revision           : 1.0
// ============================================================================
module game_link_hb_timer #(
  parameter int HB_PERIOD = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int             CW   = $clog2(HB_PERIOD);
  localparam logic [CW-1:0]  TERM = CW'(HB_PERIOD - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    tick  = (cnt_q == TERM);
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/game_link_tx.sv
`default_nettype none
// ============================================================================
// game_link_tx : turns local game events into 5-byte frames on a byte stream
// Option       : GAME_LINK_TX_SEQ_EN puts a 4-bit sequence number in TYPE[7:4]
// Revision     : 1.0
// ============================================================================
module game_link_tx
  import game_link_pkg::*;
#(
  parameter int         HB_PERIOD = 50_000_000,
  parameter logic [7:0] SYNC_BYTE = SYNC_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enter_pressed_local,
  input  logic       turn_done_local,
  input  logic [9:0] hp_local,
  input  logic [2:0] state_game_fsm,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy
);

  tx_state_t   state_q, state_d;
  frame_type_e type_q, type_d;
  logic [15:0] payload_q, payload_d;
  logic        pend_enter_q, pend_enter_d;
  logic        pend_turn_q, pend_turn_d;
  logic        pend_hp_q, pend_hp_d;
  logic        pend_hb_q, pend_hb_d;
  logic [9:0]  hp_last_q, hp_last_d;
  logic        clr_enter, clr_turn, clr_hp, clr_hb;
  logic        hb_tick;
  logic        hp_changed;
  logic [3:0]  seq_nib;
  logic [7:0]  type_byte;

  game_link_hb_timer #(
    .HB_PERIOD (HB_PERIOD)
  ) u_hb_timer (
    .clk  (clk),
    .rst  (rst),
    .tick (hb_tick)
  );

  always_comb begin
    state_d   = state_q;
    type_d    = type_q;
    payload_d = payload_q;
    clr_enter = 1'b0;
    clr_turn  = 1'b0;
    clr_hp    = 1'b0;
    clr_hb    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pend_enter_q) begin
          type_d    = FT_ENTER;
          payload_d = 16'h0000;
          clr_enter = 1'b1;
          state_d   = ST_SYNC;
        end else if (pend_turn_q) begin
          type_d    = FT_TURN;
          payload_d = {6'b0, hp_local};
          clr_turn  = 1'b1;
          state_d   = ST_SYNC;
        end else if (pend_hp_q) begin
          type_d    = FT_HP;
          payload_d = {6'b0, hp_local};
          clr_hp    = 1'b1;
          state_d   = ST_SYNC;
        end else if (pend_hb_q) begin
          type_d    = FT_HB;
          payload_d = {13'b0, state_game_fsm};
          clr_hb    = 1'b1;
          state_d   = ST_SYNC;
        end
      end
      ST_SYNC, ST_TYPE, ST_PHI, ST_PLO: begin
        if (tx_ready) state_d = state_q + 3'd1;
      end
      ST_CHK: begin
        if (tx_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Set is applied after clear so an event coinciding with its latch is kept
  always_comb begin
    hp_changed   = (hp_local != hp_last_q);
    hp_last_d    = hp_local;
    pend_enter_d = (pend_enter_q & ~clr_enter) | enter_pressed_local;
    pend_turn_d  = (pend_turn_q  & ~clr_turn)  | turn_done_local;
    pend_hp_d    = (pend_hp_q    & ~clr_hp)    | hp_changed;
    pend_hb_d    = (pend_hb_q    & ~clr_hb)    | hb_tick;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      type_q       <= FT_ENTER;
      payload_q    <= 16'h0000;
      pend_enter_q <= 1'b0;
      pend_turn_q  <= 1'b0;
      pend_hp_q    <= 1'b0;
      pend_hb_q    <= 1'b0;
      hp_last_q    <= 10'd0;
    end else begin
      state_q      <= state_d;
      type_q       <= type_d;
      payload_q    <= payload_d;
      pend_enter_q <= pend_enter_d;
      pend_turn_q  <= pend_turn_d;
      pend_hp_q    <= pend_hp_d;
      pend_hb_q    <= pend_hb_d;
      hp_last_q    <= hp_last_d;
    end
  end

`ifdef GAME_LINK_TX_SEQ_EN
  logic [3:0] seq_q, seq_d;

  always_comb begin
    seq_d = seq_q;
    if (state_q == ST_CHK && tx_ready) seq_d = seq_q + 4'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seq_q <= 4'd0;
    end else begin
      seq_q <= seq_d;
    end
  end

  assign seq_nib = seq_q;
`else
  assign seq_nib = 4'h0;
`endif

  // All frame type codes have a zero upper nibble, leaving room for the sequence
  assign type_byte = type_q | {seq_nib, 4'h0};

  always_comb begin
    tx_data = 8'h00;
    case (state_q)
      ST_SYNC: tx_data = SYNC_BYTE;
      ST_TYPE: tx_data = type_byte;
      ST_PHI:  tx_data = payload_q[15:8];
      ST_PLO:  tx_data = payload_q[7:0];
      ST_CHK:  tx_data = frame_chk(type_byte, payload_q);
      default: tx_data = 8'h00;
    endcase
  end

  assign tx_valid = (state_q != ST_IDLE);
  assign busy     = tx_valid;

endmodule
`default_nettype wire

// File: tb/tb_game_link_tx.sv
`default_nettype none
// ============================================================================
// tb_game_link_tx : randomized scoreboard bench for game_link_tx (HB_PERIOD=16)
// Revision        : 1.0
// ============================================================================
module tb_game_link_tx;

  localparam int HBP = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enter = 1'b0;
  logic       turn = 1'b0;
  logic [9:0] hp = 10'd0;
  logic [2:0] fsm = 3'b001;
  logic       tx_ready = 1'b1;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       busy;

  int checks = 0;
  int errors = 0;

  game_link_tx #(
    .HB_PERIOD (HBP),
    .SYNC_BYTE (8'hA5)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .enter_pressed_local (enter),
    .turn_done_local     (turn),
    .hp_local            (hp),
    .state_game_fsm      (fsm),
    .tx_data             (tx_data),
    .tx_valid            (tx_valid),
    .tx_ready            (tx_ready),
    .busy                (busy)
  );

  always #5 clk = ~clk;

  // Reference model: pending set per frame kind, link either free or sending
  logic [7:0] exp_q[$];
  bit         m_pend[4];
  logic [9:0] m_hp_last;
  int         m_k;
  bit         m_busy;
  int         m_left;
  int         m_seq;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_pend[i] = 1'b0;
    m_hp_last = 10'd0;
    m_k       = 0;
    m_busy    = 1'b0;
    m_left    = 0;
    m_seq     = 0;
    exp_q.delete();
  endtask

  task automatic push_frame(input int kind);
    logic [7:0]  t;
    logic [15:0] p;
    t = 8'(kind + 1);
    case (kind)
      0:       p = 16'h0000;
      1, 2:    p = {6'b0, hp};
      default: p = {13'b0, fsm};
    endcase
`ifdef GAME_LINK_TX_SEQ_EN
    t = t | 8'(m_seq * 16);
`endif
    exp_q.push_back(8'hA5);
    exp_q.push_back(t);
    exp_q.push_back(p[15:8]);
    exp_q.push_back(p[7:0]);
    exp_q.push_back(t ^ p[15:8] ^ p[7:0]);
  endtask

  always @(posedge clk) begin
    if (rst) begin
      model_reset();
    end else begin
      if (m_busy) begin
        if (tx_ready) begin
          m_left = m_left - 1;
          if (m_left == 0) begin
            m_busy = 1'b0;
            m_seq  = (m_seq + 1) % 16;
          end
        end
      end else begin
        for (int i = 0; i < 4; i++) begin
          if (m_pend[i]) begin
            push_frame(i);
            m_pend[i] = 1'b0;
            m_busy    = 1'b1;
            m_left    = 5;
            break;
          end
        end
      end
      if (enter) m_pend[0] = 1'b1;
      if (turn) m_pend[1] = 1'b1;
      if (hp != m_hp_last) m_pend[2] = 1'b1;
      m_hp_last = hp;
      if (m_k % HBP == HBP - 1) m_pend[3] = 1'b1;
      m_k = m_k + 1;
    end
  end

  // Monitor
  bit         prev_hold = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic [7:0] exp_b;

  always @(negedge clk) begin
    if (rst) begin
      prev_hold = 1'b0;
    end else begin
      checks++;
      if (tx_valid !== m_busy || busy !== m_busy) begin
        errors++;
        $display("FAIL valid_busy t=%0t tx_valid=%b busy=%b required=%b", $time, tx_valid, busy, m_busy);
      end
      if (prev_hold) begin
        checks++;
        if (!(tx_valid === 1'b1 && tx_data === prev_data)) begin
          errors++;
          $display("FAIL hold_stable t=%0t tx_valid=%b tx_data=%h required valid=1 data=%h", $time, tx_valid, tx_data, prev_data);
        end
      end
      if (tx_valid === 1'b1 && tx_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_byte t=%0t tx_data=%h required no byte", $time, tx_data);
        end else begin
          exp_b = exp_q.pop_front();
          if (tx_data !== exp_b) begin
            errors++;
            $display("FAIL frame_byte t=%0t tx_data=%h required=%h", $time, tx_data, exp_b);
          end
        end
      end
      prev_hold = (tx_valid === 1'b1) && !tx_ready;
      prev_data = tx_data;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    enter = 1'b0;
    turn  = 1'b0;
    repeat (n) step();
  endtask

  task automatic check_now(input string name, input logic [9:0] act, input logic [9:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, req);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s t=%0t actual=timeout required=event", name, $time);
  endtask

  task automatic random_phase(input int n, input int ready_mode);
    for (int i = 0; i < n; i++) begin
      enter = ($urandom_range(0, 7) == 0);
      turn  = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 15) == 0) hp = 10'($urandom_range(0, 1023));
      if ($urandom_range(0, 31) == 0) fsm = 3'($urandom_range(0, 7));
      case (ready_mode)
        0:       tx_ready = 1'b1;
        1:       tx_ready = ~tx_ready;
        default: tx_ready = ($urandom_range(0, 3) != 0);
      endcase
      step();
    end
    enter = 1'b0;
    turn  = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout_fail(name);
  endtask

  initial begin
    model_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_now("reset_tx_valid", {9'b0, tx_valid}, 10'd0);
    check_now("reset_busy", {9'b0, busy}, 10'd0);
    check_now("reset_tx_data", {2'b0, tx_data}, 10'd0);
    #2 rst = 1'b0;

    // Single enter frame, hp at zero so no HP frame
    step();
    enter = 1'b1;
    step();
    idle_cycles(10);

    // HP 100 -> 75
    hp = 10'd100;
    idle_cycles(10);
    hp = 10'd75;
    idle_cycles(10);

    // Enter and turn in the same cycle
    hp = 10'd300;
    idle_cycles(8);
    enter = 1'b1;
    turn  = 1'b1;
    step();
    idle_cycles(20);

    // Ready toggling, then quiet heartbeat-only stretch
    random_phase(300, 1);
    tx_ready = 1'b1;
    fsm = 3'b001;
    idle_cycles(64);

    random_phase(2000, 2);
    random_phase(300, 0);

    // Reset while the PHI byte is on the bus
    tx_ready = 1'b1;
    idle_cycles(1);
    wait_idle("wait_idle_pre_reset");
    tx_ready = 1'b0;
    enter = 1'b1;
    step();
    enter = 1'b0;
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
        step();
        if (tx_valid) begin
          seen = 1'b1;
          break;
        end
      end
      if (!seen) timeout_fail("wait_frame_start");
    end
    tx_ready = 1'b1;
    step();
    step();
    tx_ready = 1'b0;
    #3 rst = 1'b1;
    #1;
    check_now("async_reset_valid", {9'b0, tx_valid}, 10'd0);
    check_now("async_reset_busy", {9'b0, busy}, 10'd0);
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    tx_ready = 1'b1;

    random_phase(500, 2);

    // Drain
    tx_ready = 1'b1;
    begin
      bit drained;
      drained = 1'b0;
      for (int i = 0; i < 200; i++) begin
        @(negedge clk);
        #1;
        if (exp_q.size() == 0 && !busy) begin
          drained = 1'b1;
          break;
        end
      end
      if (!drained) timeout_fail("drain");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
